// File: rtl/adc_scan_ctrl.sv
// adc_scan_ctrl: continuous ADC channel-scan sequencer with per-channel averaging.
// Each conversion pulses adc_start, waits for adc_ready (or times out), accumulates
// the sample, and after 2^AVG_LOG2 samples publishes the channel average.
// Optional feature macro: ADC_ROUND_EN (round-half-up average with saturation;
// when undefined the average is a plain truncating shift).
module adc_scan_ctrl #(
  parameter int NUM_CH      = 2,
  parameter int VALUE_W     = 14,
  parameter int AVG_LOG2    = 3,
  parameter int TIMEOUT_CYC = 255,
  parameter int GAP_CYC     = 2
) (
  input  logic               adc_clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               adc_ready,
  input  logic [VALUE_W-1:0] adc_value,
  output logic               adc_start,
  output logic [2:0]         adc_channel_ind,
  output logic [3:0]         adc_counts,
  output logic [VALUE_W-1:0] adc_current_0,
  output logic [VALUE_W-1:0] adc_current_1,
  output logic               scan_done,
  output logic               timeout_err
);

  localparam int AW = VALUE_W + AVG_LOG2;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [4:0] WIN = 5'(1 << AVG_LOG2);

  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_CAPTURE, S_NEXT} state_t;

  state_t                     state, state_nxt;
  logic [TW-1:0]              tmr;
  logic [GW-1:0]              gap;
  logic [VALUE_W-1:0]         sample;
  logic [AW-1:0]              acc, acc_sum;
  logic [3:0]                 cnt;
  logic [2:0]                 ch;
  logic [1:0][VALUE_W-1:0]    cur;
  logic [VALUE_W-1:0]         avg;
  logic                       wait_to, gap_last, win_done, last_ch;

  assign acc_sum  = acc + AW'(sample);
  assign win_done = ({1'b0, cnt} + 5'd1) == WIN;
  assign last_ch  = ch == 3'(NUM_CH - 1);
  assign wait_to  = (state == S_WAIT) && !adc_ready && (tmr == TW'(TIMEOUT_CYC - 1));
  assign gap_last = gap == GW'(GAP_CYC - 1);

`ifdef ADC_ROUND_EN
  // Round half up; the extra bit catches the carry so we can saturate.
  logic [AW:0]        rsum;
  logic [VALUE_W:0]   rshift;
  assign rsum   = {1'b0, acc_sum} + (AW+1)'(1 << (AVG_LOG2 - 1));
  assign rshift = (VALUE_W+1)'(rsum >> AVG_LOG2);
  assign avg    = rshift[VALUE_W] ? {VALUE_W{1'b1}} : rshift[VALUE_W-1:0];
`else
  // Truncating average: the window sum shifted down, no rounding adder.
  assign avg = VALUE_W'(acc_sum >> AVG_LOG2);
`endif

  // State register.
  always_ff @(posedge adc_clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: one conversion per START..NEXT pass; enable only matters in IDLE/NEXT.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (enable) state_nxt = S_START;
      S_START:   state_nxt = S_WAIT;
      S_WAIT: begin
        if (adc_ready)    state_nxt = S_CAPTURE;
        else if (wait_to) state_nxt = S_NEXT;
      end
      S_CAPTURE: state_nxt = S_NEXT;
      S_NEXT:    if (gap_last) state_nxt = enable ? S_START : S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Datapath: timers, sample latch, accumulator, channel stepping, result registers.
  always_ff @(posedge adc_clk) begin
    if (!rst_n) begin
      tmr         <= '0;
      gap         <= '0;
      sample      <= '0;
      acc         <= '0;
      cnt         <= '0;
      ch          <= '0;
      cur         <= '0;
      scan_done   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      scan_done <= 1'b0;
      gap       <= (state == S_NEXT) ? gap + GW'(1) : '0;
      case (state)
        S_START: tmr <= '0;
        S_WAIT: begin
          tmr <= tmr + TW'(1);
          if (adc_ready)    sample      <= adc_value;
          else if (wait_to) timeout_err <= 1'b1;
        end
        S_CAPTURE: begin
          if (win_done) begin
            // Window complete: publish, restart window, step channel.
            for (int i = 0; i < 2; i++)
              if (i < NUM_CH && ch == 3'(i)) cur[i] <= avg;
            acc <= '0;
            cnt <= '0;
            if (last_ch) begin
              ch        <= '0;
              scan_done <= 1'b1;
            end else begin
              ch <= ch + 3'd1;
            end
          end else begin
            acc <= acc_sum;
            cnt <= cnt + 4'd1;
          end
        end
        S_NEXT: begin
          // Leaving to IDLE drops any partial window.
          if (gap_last && !enable) begin
            acc <= '0;
            cnt <= '0;
            ch  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign adc_start       = (state == S_START);
  assign adc_channel_ind = ch;
  assign adc_counts      = cnt;
  assign adc_current_0   = cur[0];
  assign adc_current_1   = cur[1];

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Bench for adc_scan_ctrl: a transaction-level model of the scan (window sums,
// channel sequence, averages) plus an ADC responder answering 3 cycles after adc_start.
module tb_adc_scan_ctrl;
  localparam int AVG_LOG2 = 3;
`ifdef ADC_ROUND_EN
  localparam int EXP_T2 = 104;
`else
  localparam int EXP_T2 = 103;
`endif

  logic        adc_clk = 1'b0;
  logic        rst_n = 1'b0, enable = 1'b0, adc_ready = 1'b0;
  logic [13:0] adc_value = '0;
  logic        adc_start, scan_done, timeout_err;
  logic [2:0]  adc_channel_ind;
  logic [3:0]  adc_counts;
  logic [13:0] adc_current_0, adc_current_1;

  always #5 adc_clk = ~adc_clk;

  adc_scan_ctrl dut (
    .adc_clk(adc_clk), .rst_n(rst_n), .enable(enable), .adc_ready(adc_ready),
    .adc_value(adc_value), .adc_start(adc_start), .adc_channel_ind(adc_channel_ind),
    .adc_counts(adc_counts), .adc_current_0(adc_current_0), .adc_current_1(adc_current_1),
    .scan_done(scan_done), .timeout_err(timeout_err)
  );

  int checks = 0, errors = 0;

  // model state
  int m_ch = 0, m_cnt = 0, m_acc = 0, m_scans = 0;
  int m_cur[2] = '{0, 0};
  bit m_to = 0;
  // responder / bookkeeping
  int mode = 2, pend = 0, sd_due = 0, cyc = 0, prev_start = 0;
  bit prev_valid = 0, last_to = 0, withhold = 0, ready_in_start = 0;
  int n_starts = 0, n_ready = 0, n_sd = 0, max_cnt = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic int sample_val();
    if (mode == 2) return (m_ch == 0) ? 100 + m_cnt : 50;
    return (m_ch == 0) ? 16383 : 1;
  endfunction

  function automatic int avg_of(int acc);
    int r;
`ifdef ADC_ROUND_EN
    r = (acc + (1 << (AVG_LOG2 - 1))) >> AVG_LOG2;
    if (r > 16383) r = 16383;
`else
    r = acc >> AVG_LOG2;
`endif
    return r;
  endfunction

  task automatic model_sample(int v);
    m_acc += v;
    m_cnt++;
    if (m_cnt == (1 << AVG_LOG2)) begin
      m_cur[m_ch] = avg_of(m_acc);
      m_acc = 0;
      m_cnt = 0;
      if (m_ch == 1) begin
        m_ch = 0;
        m_scans++;
        sd_due = 2;
      end else m_ch++;
    end
  endtask

  task automatic model_reset();
    m_ch = 0; m_cnt = 0; m_acc = 0; m_scans = 0; m_to = 0;
    m_cur[0] = 0; m_cur[1] = 0;
  endtask

  task automatic model_idle();
    m_ch = 0; m_cnt = 0; m_acc = 0; prev_valid = 0;
  endtask

  // Compare + ADC responder, all on the falling edge.
  always @(negedge adc_clk) begin
    cyc++;
    if (!rst_n) begin
      pend = 0; sd_due = 0; adc_ready = 0; prev_valid = 0;
    end else begin
      chk("scan_done", {31'd0, scan_done}, {31'd0, sd_due == 1});
      if (sd_due > 0) sd_due--;
      if (scan_done) n_sd++;
      adc_ready = 0;
      if (adc_start) begin
        n_starts++;
        if (int'(adc_counts) > max_cnt) max_cnt = int'(adc_counts);
        chk("start_ch", adc_channel_ind, m_ch);
        chk("start_counts", adc_counts, m_cnt);
        chk("cur0", adc_current_0, m_cur[0]);
        chk("cur1", adc_current_1, m_cur[1]);
        chk("timeout_err", timeout_err, m_to);
        if (prev_valid) chk("start_period", cyc - prev_start, last_to ? 258 : 7);
        prev_start = cyc; prev_valid = 1; last_to = 0;
      end
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          adc_value = 14'(sample_val());
          adc_ready = 1;
          n_ready++;
          model_sample(int'(adc_value));
        end
      end
      if (adc_start) begin
        if (withhold) begin
          withhold = 0; last_to = 1; m_to = 1;
        end else pend = 3;
        if (ready_in_start) begin
          ready_in_start = 0; adc_ready = 1; adc_value = 14'h2AAA;
        end
      end
    end
  end

  task automatic tick(int n);
    repeat (n) begin @(posedge adc_clk); #1; end
  endtask

  task automatic wait_starts(int n, int budget);
    int target = n_starts + n;
    int k = 0;
    while (n_starts < target && k < budget) begin tick(1); k++; end
    chk("wait_starts_bound", {31'd0, n_starts >= target}, 1);
  endtask

  task automatic wait_ready(int n, int budget);
    int target = n_ready + n;
    int k = 0;
    while (n_ready < target && k < budget) begin tick(1); k++; end
    chk("wait_ready_bound", {31'd0, n_ready >= target}, 1);
  endtask

  task automatic check_zero(string nm);
    chk({nm, "_start"}, adc_start, 0);
    chk({nm, "_ch"}, adc_channel_ind, 0);
    chk({nm, "_counts"}, adc_counts, 0);
    chk({nm, "_cur0"}, adc_current_0, 0);
    chk({nm, "_cur1"}, adc_current_1, 0);
    chk({nm, "_done"}, scan_done, 0);
    chk({nm, "_to"}, timeout_err, 0);
  endtask

  task automatic do_reset();
    rst_n = 0;
    tick(2);
    model_reset();
    check_zero("rst");
    rst_n = 1;
  endtask

  initial begin
    int s0, c0, sd0;
    // 1: reset and idle with enable low
    enable = 0;
    tick(2);
    check_zero("t1_rst");
    model_reset();
    rst_n = 1;
    tick(10);
    chk("t1_no_start", n_starts, 0);
    check_zero("t1_idle");

    // 2: averaging on channel 0 (samples 100..107)
    mode = 2;
    enable = 1;
    wait_starts(9, 200);
    chk("t2_avg0", adc_current_0, EXP_T2);
    chk("t2_ch_next", adc_channel_ind, 1);

    // 3: full scan with constant inputs
    do_reset();
    mode = 3;
    sd0 = n_sd;
    max_cnt = 0;
    wait_starts(33, 400);
    chk("t3_cur0", adc_current_0, 16'h3FFF);
    chk("t3_cur1", adc_current_1, 1);
    chk("t3_scans", n_sd - sd0, 2);
    chk("t3_max_counts", max_cnt, 7);

    // 4: timeout on one conversion, then normal resumption
    withhold = 1;
    wait_starts(1, 50);
    tick(250);
    chk("t4_to_early", timeout_err, 0);
    wait_starts(1, 300);
    chk("t4_to_set", timeout_err, 1);
    chk("t4_counts_kept", adc_counts, 1);
    ready_in_start = 1;
    wait_starts(3, 100);

    // 5: drop enable mid-WAIT
    wait_starts(1, 50);
    c0 = int'(adc_counts);
    enable = 0;
    tick(4);
    chk("t5_captured", adc_counts, (c0 + 1) % 8);
    s0 = n_starts;
    tick(8);
    model_idle();
    chk("t5_no_start", n_starts, s0);
    chk("t5_idle_counts", adc_counts, 0);
    chk("t5_idle_ch", adc_channel_ind, 0);
    chk("t5_to_kept", timeout_err, 1);
    enable = 1;
    wait_starts(2, 100);

    // 6: reset after 5 samples of a fresh window
    do_reset();
    mode = 2;
    wait_ready(5, 200);
    tick(2);
    rst_n = 0;
    tick(2);
    model_reset();
    check_zero("t6_rst");
    rst_n = 1;
    wait_starts(1, 50);
    chk("t6_cur0", adc_current_0, 0);
    chk("t6_counts", adc_counts, 0);
    wait_starts(8, 200);
    chk("t6_avg0", adc_current_0, EXP_T2);

    enable = 0;
    tick(20);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
